// File: rtl/comp_pkg.sv
// Shared constants, state type and helpers for the zero-pad generator/strip pair.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DATA_W, SIZE_W, BLOCK_WORDS : word width, size-field width, words per block
//   BLOCK_CNT                   : BLOCK_WORDS sized to the word counter width
//   strip_state_e               : strip FSM states
//   pay_words()                 : payload word count from a comp_size field
package comp_pkg;

  localparam int DATA_W      = 64;
  localparam int SIZE_W      = 3;
  localparam int BLOCK_WORDS = 1 << SIZE_W;

  // Word counter is SIZE_W+1 bits so a full block count fits without wrapping.
  localparam logic [SIZE_W:0] BLOCK_CNT = (SIZE_W+1)'(BLOCK_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    PAD
  } strip_state_e;

  // comp_size encodes payload length minus one.
  function automatic logic [SIZE_W:0] pay_words(input logic [SIZE_W-1:0] comp_size);
    return {1'b0, comp_size} + 1'b1;
  endfunction

endpackage

// File: rtl/out_reg_slice.sv
// Single-entry valid/ready register carrying one data word plus its eop flag.
// Latency: 1 cycle from load to o_vld.
// Backpressure: o_rdy = !full | i_rdy, so a drain and a new load can share a cycle.
//
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   i_vld/i_dat/i_eop: load request (only asserted when o_rdy is high)
//   o_rdy            : slot can take a word this cycle
//   o_vld/o_dat/o_eop: registered output toward the consumer
//   i_rdy            : consumer accepts the presented word
module out_reg_slice
  import comp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_vld,
  input  logic [DATA_W-1:0] i_dat,
  input  logic              i_eop,
  output logic              o_rdy,
  output logic              o_vld,
  output logic [DATA_W-1:0] o_dat,
  output logic              o_eop,
  input  logic              i_rdy
);

  logic              r_vld;
  logic [DATA_W-1:0] r_dat;
  logic              r_eop;

  assign o_rdy = !r_vld | i_rdy;
  assign o_vld = r_vld;
  assign o_dat = r_dat;
  assign o_eop = r_eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_eop <= 1'b0;
    end else if (i_vld && o_rdy) begin
      r_vld <= 1'b1;
      r_dat <= i_dat;
      r_eop <= i_eop;
    end else if (i_rdy) begin
      // Drained with nothing new behind it; data/eop left as-is (not observed).
      r_vld <= 1'b0;
    end
  end

endmodule

// File: rtl/zero_pad_strip.sv
// Strips trailing zero-pad words from fixed-size blocks and forwards payload with eop.
// Latency: payload word accepted in cycle N appears on out_* in cycle N+1.
// Backpressure: IDLE/PAYLOAD stall on the output slot; pad words are dropped without stalling.
//
// Ports:
//   clk, rst                               : clock, synchronous active-high reset
//   in_data_i/in_valid_i/in_ready_o        : word stream from memory controller
//   in_sop_i, comp_size_i                  : block start marker and payload size-1
//   out_data_o/out_valid_o/out_ready_i     : payload stream to decompressor engine
//   out_eop_o                              : last payload word of a block
//   pad_err_o, frame_err_o                 : sticky error flags, cleared only by rst
//   busy_o                                 : block in progress or output slot full
module zero_pad_strip
  import comp_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_sop_i,
  input  logic [SIZE_W-1:0] comp_size_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              out_eop_o,
  output logic              pad_err_o,
  output logic              frame_err_o,
  output logic              busy_o
);

  strip_state_e      r_state;
  logic [SIZE_W-1:0] r_pay_left;
  logic [SIZE_W:0]   r_word_cnt;
  logic              r_pad_err;
  logic              r_frame_err;

  logic              w_slot_rdy;
  logic              w_in_rdy;
  logic              w_acc;
  logic              w_load;
  logic              w_load_eop;
  logic [SIZE_W:0]   w_cnt_nxt;

  assign w_cnt_nxt = r_word_cnt + 1'b1;

  always_comb begin
    w_in_rdy = 1'b0;
    if (!rst) begin
      if (r_state == PAD) begin
        // Pad words never wait on the engine, but a re-sync sop word is a
        // payload word and needs room in the output slot.
        w_in_rdy = !(in_valid_i && in_sop_i) || w_slot_rdy;
      end else begin
        w_in_rdy = w_slot_rdy;
      end
    end
  end

  assign in_ready_o = w_in_rdy;
  assign w_acc      = in_valid_i && w_in_rdy;

  // A sop word always starts a new block, whatever state we were in.
  assign w_load     = w_acc && (in_sop_i || (r_state == PAYLOAD));
  assign w_load_eop = in_sop_i ? (pay_words(comp_size_i) == (SIZE_W+1)'(1))
                               : (r_pay_left == SIZE_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pay_left  <= '0;
      r_word_cnt  <= '0;
      r_pad_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else if (w_acc) begin
      if (in_sop_i) begin
        if (r_state != IDLE) begin
          r_frame_err <= 1'b1;
        end
        r_pay_left <= comp_size_i;
        if (pay_words(comp_size_i) != (SIZE_W+1)'(1)) begin
          r_state    <= PAYLOAD;
          r_word_cnt <= (SIZE_W+1)'(1);
        end else if (BLOCK_CNT == (SIZE_W+1)'(1)) begin
          r_state    <= IDLE;
          r_word_cnt <= '0;
        end else begin
          r_state    <= PAD;
          r_word_cnt <= (SIZE_W+1)'(1);
        end
      end else begin
        unique case (r_state)
          IDLE: begin
            // Word outside any block: dropped.
            r_frame_err <= 1'b1;
          end
          PAYLOAD: begin
            r_pay_left <= r_pay_left - 1'b1;
            r_word_cnt <= w_cnt_nxt;
            if (r_pay_left == SIZE_W'(1)) begin
              if (w_cnt_nxt < BLOCK_CNT) begin
                r_state <= PAD;
              end else begin
                r_state    <= IDLE;
                r_word_cnt <= '0;
              end
            end
          end
          PAD: begin
            if (in_data_i != '0) begin
              r_pad_err <= 1'b1;
            end
            r_word_cnt <= w_cnt_nxt;
            if (w_cnt_nxt == BLOCK_CNT) begin
              r_state    <= IDLE;
              r_word_cnt <= '0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  out_reg_slice u_out_reg_slice (
    .clk   (clk),
    .rst   (rst),
    .i_vld (w_load),
    .i_dat (in_data_i),
    .i_eop (w_load_eop),
    .o_rdy (w_slot_rdy),
    .o_vld (out_valid_o),
    .o_dat (out_data_o),
    .o_eop (out_eop_o),
    .i_rdy (out_ready_i)
  );

  assign pad_err_o   = r_pad_err;
  assign frame_err_o = r_frame_err;
  assign busy_o      = (r_state != IDLE) || out_valid_o;

endmodule

// File: tb/tb_zero_pad_strip.sv
// Directed bench for zero_pad_strip with a block-level reference model and scoreboard.
// Latency: n/a.
// Backpressure: out_ready_i driven per test mode (always high, toggling, held low).
module tb_zero_pad_strip;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_sop_i;
  logic [2:0]  comp_size_i;
  logic [63:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_eop_o;
  logic        pad_err_o;
  logic        frame_err_o;
  logic        busy_o;

  zero_pad_strip dut (
    .clk         (clk),
    .rst         (rst),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_sop_i    (in_sop_i),
    .comp_size_i (comp_size_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_eop_o   (out_eop_o),
    .pad_err_o   (pad_err_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  localparam int BLK = 8;

  int tests = 0;
  int fails = 0;

  // Block-level reference model state.
  logic [64:0] q[$];      // {eop, data} words owed to the engine
  bit          m_in_block;
  int          m_pos;
  int          m_pay;
  bit          m_pad;
  bit          m_frame;

  // Per-test observations.
  int          n_out;
  int          n_eop;
  int          eop_at;
  logic [63:0] out_log[$];
  int          rdy_mode = 0;   // 0: ready high, 1: toggle, 2: held low

  bit          p_stall;
  logic [63:0] p_dat;
  logic        p_eop;
  bit          post_rst;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat(input int blk, input int i);
    return {8'hA5, 40'h0, blk[7:0], i[7:0]};
  endfunction

  task automatic model_word(input logic [63:0] d, input logic sop, input logic [2:0] cs);
    if (sop) begin
      if (m_in_block) m_frame = 1'b1;
      m_in_block = 1'b1;
      m_pos      = 0;
      m_pay      = int'(cs) + 1;
    end else if (!m_in_block) begin
      m_frame = 1'b1;
      return;
    end
    if (m_pos < m_pay) q.push_back({(m_pos == m_pay - 1), d});
    else if (d != 64'd0) m_pad = 1'b1;
    m_pos++;
    if (m_pos == BLK) m_in_block = 1'b0;
  endtask

  // Compare process: everything sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        check("rst_in_ready", in_ready_o, 1'b0);
        q.delete();
        m_in_block = 0; m_pos = 0; m_pay = 0; m_pad = 0; m_frame = 0;
        p_stall = 0; post_rst = 1;
      end else begin
        bit full, in_pad, exp_rdy;
        full    = (q.size() != 0);
        in_pad  = m_in_block && (m_pos >= m_pay);
        exp_rdy = in_pad ? (!(in_valid_i && in_sop_i) || !full || out_ready_i)
                         : (!full || out_ready_i);
        check("in_ready", in_ready_o, exp_rdy);
        check("out_valid", out_valid_o, full);
        check("busy", busy_o, m_in_block || full);
        check("pad_err", pad_err_o, m_pad);
        check("frame_err", frame_err_o, m_frame);
        if (post_rst) begin
          check("rst_out_data", out_data_o, 64'd0);
          check("rst_out_eop", out_eop_o, 1'b0);
          post_rst = 0;
        end
        if (p_stall) begin
          check("stall_data", out_data_o, p_dat);
          check("stall_eop", out_eop_o, p_eop);
        end
        if (out_valid_o && out_ready_i) begin
          if (q.size() == 0) begin
            check("unexpected_out", 1'b1, 1'b0);
          end else begin
            logic [64:0] e;
            e = q.pop_front();
            check("out_data", out_data_o, e[63:0]);
            check("out_eop", out_eop_o, e[64]);
          end
          out_log.push_back(out_data_o);
          n_out++;
          if (out_eop_o) begin
            n_eop++;
            eop_at = n_out;
          end
        end
        p_stall = out_valid_o && !out_ready_i;
        p_dat   = out_data_o;
        p_eop   = out_eop_o;
        if (in_valid_i && in_ready_o) model_word(in_data_i, in_sop_i, comp_size_i);
      end
    end
  end

  // Engine-side ready driver.
  initial begin
    out_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready_i = 1'b1;
        1:       out_ready_i = ~out_ready_i;
        default: out_ready_i = 1'b0;
      endcase
    end
  end

  time t_acc;

  task automatic send(input logic [63:0] d, input logic sop, input logic [2:0] cs);
    bit ok;
    ok          = 0;
    in_valid_i  = 1'b1;
    in_data_i   = d;
    in_sop_i    = sop;
    comp_size_i = cs;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready_o) begin
        ok    = 1;
        t_acc = $time;
        break;
      end
    end
    if (!ok) check("accept_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    in_sop_i   = 1'b0;
  endtask

  // Full 8-word block: payload words carry a pattern, pad words zero except nz_idx.
  task automatic send_block(input int blk, input logic [2:0] cs, input int nz_idx);
    for (int i = 0; i < BLK; i++) begin
      send((i <= int'(cs)) ? pat(blk, i) : ((i == nz_idx) ? 64'd1 : 64'd0), (i == 0), cs);
    end
  endtask

  task automatic clr_obs();
    n_out = 0; n_eop = 0; eop_at = 0;
    out_log.delete();
  endtask

  task automatic drain();
    rdy_mode = 0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  time t0;

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; in_sop_i = 1'b0; in_data_i = '0; comp_size_i = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid_o, 1'b0);
    check("reset_busy", busy_o, 1'b0);
    @(posedge clk);
    #1;

    // comp_size 3, zero pads: 4 words out, ready every cycle.
    clr_obs();
    send(pat(1, 0), 1'b1, 3'd3);
    t0 = t_acc;
    for (int i = 1; i < BLK; i++) send((i <= 3) ? pat(1, i) : 64'd0, 1'b0, 3'd3);
    check("t1_span", 64'(t_acc - t0), 64'd70);
    drain();
    check("t1_n_out", n_out, 4);
    check("t1_eop_at", eop_at, 4);
    check("t1_first", out_log[0], 64'hA500_0000_0000_0100);
    check("t1_pad_err", pad_err_o, 1'b0);
    check("t1_frame_err", frame_err_o, 1'b0);

    // comp_size 7 followed directly by the comp_size 0 block.
    clr_obs();
    send_block(2, 3'd7, -1);
    t0 = t_acc;
    send(pat(3, 0), 1'b1, 3'd0);
    check("t2_next_sop", 64'(t_acc - t0), 64'd10);
    check("t2_n_out", n_out, 8);
    check("t2_eop_at", eop_at, 8);
    clr_obs();
    for (int i = 1; i < BLK; i++) send((i == 5) ? 64'd1 : 64'd0, 1'b0, 3'd0);
    drain();
    check("t3_n_out", n_out, 1);
    check("t3_n_eop", n_eop, 1);
    check("t3_pad_err", pad_err_o, 1'b1);

    // comp_size 5 under toggling engine ready.
    clr_obs();
    rdy_mode = 1;
    send_block(4, 3'd5, -1);
    drain();
    check("t4_n_out", n_out, 6);
    check("t4_eop_at", eop_at, 6);
    check("t4_last", out_log[5], 64'hA500_0000_0000_0405);

    // Reset mid-PAYLOAD with the output register full.
    clr_obs();
    send(pat(7, 0), 1'b1, 3'd7);
    send(pat(7, 1), 1'b0, 3'd7);
    rdy_mode = 2;
    send(pat(7, 2), 1'b0, 3'd7);
    @(negedge clk);
    check("t6_valid_before", out_valid_o, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_valid_after", out_valid_o, 1'b0);
    check("t6_data_after", out_data_o, 64'd0);
    check("t6_pad_after", pad_err_o, 1'b0);
    @(posedge clk);
    #1;
    rdy_mode = 0;
    clr_obs();
    send_block(8, 3'd1, -1);
    drain();
    check("t6_n_out", n_out, 2);
    check("t6_eop_at", eop_at, 2);

    // Non-sop word while idle: dropped, frame error.
    clr_obs();
    send(64'h1234, 1'b0, 3'd0);
    drain();
    check("t7_n_out", n_out, 0);
    check("t7_frame_err", frame_err_o, 1'b1);

    // sop at word 3 of a comp_size 6 block re-syncs onto the new block.
    clr_obs();
    for (int i = 0; i < 3; i++) send(pat(5, i), (i == 0), 3'd6);
    send_block(6, 3'd2, -1);
    drain();
    check("t5_n_out", n_out, 6);
    check("t5_n_eop", n_eop, 1);
    check("t5_eop_at", eop_at, 6);
    check("t5_resync_word", out_log[3], 64'hA500_0000_0000_0600);
    check("t5_busy", busy_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/zero_pad_strip.md
# zero_pad_strip

Decompression-side counterpart of the zero-padding generator. Accepts fixed-size blocks of 64-bit words from the memory controller, forwards the first `comp_size_i + 1` payload words of each block to the decompressor engine with an end-of-packet marker, and consumes and drops the trailing zero-pad words. Non-zero pad words and mis-framed blocks raise sticky error flags.

## Interface
- `DATA_W`, 64: word width.
- `BLOCK_WORDS`, 8: words per stored block (payload plus pad).
- `SIZE_W`, 3: width of `comp_size_i`; `BLOCK_WORDS` = 2**`SIZE_W`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data_i`  in  DATA_W  word from memory ctrl.
- `in_valid_i`  in  1  `in_data_i` valid.
- `in_ready_o`  out  1  block accepts the word this cycle.
- `in_sop_i`  in  1  first word of a block; qualified by `in_valid_i`.
- `comp_size_i`  in  SIZE_W  payload word count minus 1; sampled with the sop word.
- `out_data_o`  out  DATA_W  payload word to engine.
- `out_valid_o`  out  1  `out_data_o` valid.
- `out_ready_i`  in  1  engine accepts.
- `out_eop_o`  out  1  last payload word of block; qualified by `out_valid_o`.
- `pad_err_o`  out  1  sticky: a dropped pad word was non-zero.
- `frame_err_o`  out  1  sticky: sop missing at block start or present mid-block.
- `busy_o`  out  1  state ≠ IDLE or output register full.

## Operation
- Transfer on either side occurs when valid & ready are both high in the same cycle.
- States:
  - IDLE
    - On accepted word with `in_sop_i`: latch `pay_left = comp_size_i`, `word_cnt = 1`, and load the word into the output register.
    - If `comp_size_i == 0`, set eop on that word; next state is PAD, or IDLE when BLOCK_WORDS == 1. Otherwise next state is PAYLOAD.
    - Accepted word without sop: set `frame_err_o`, drop the word, stay in IDLE.
  - PAYLOAD
    - Each accepted word is loaded into the output register; `pay_left` decrements.
    - Word with `pay_left == 1` before decrement carries eop. Next state is PAD if `word_cnt + 1 < BLOCK_WORDS`, else IDLE.
  - PAD
    - Each accepted word is dropped. If it is non-zero, set `pad_err_o`.
    - Return to IDLE after the word that makes `word_cnt == BLOCK_WORDS`.
- `word_cnt` counts accepted words in the current block. It is SIZE_W+1 bits wide and never wraps within a block.
- `in_sop_i` on any accepted word in PAYLOAD or PAD: set `frame_err_o`, discard the current block state, and treat the word as a new sop in IDLE, all in the same cycle. This re-sync also applies when the output register is full:
  - The pending payload word is kept and delivered as-is; it carries no eop unless one was already set.
  - The new sop word is accepted only when `in_ready_o` allows it.
- Error flags clear only on `rst`.

## Timing
- Reset values: `in_ready_o`=0 during the `rst` cycle; `out_valid_o`=0, `out_eop_o`=0, `out_data_o`=0, `pad_err_o`=0, `frame_err_o`=0, `busy_o`=0; state IDLE, counters 0.
- Latency: a payload word accepted in cycle N is presented on `out_*` in cycle N+1.
- Output register is one entry with bypass on drain.
- `in_ready_o` per state:
  - IDLE and PAYLOAD: `!out_valid_o | out_ready_i`, combinational from `out_ready_i`.
  - PAD: 1, independent of `out_ready_i`.
- Full throughput: one word per cycle while `out_ready_i` stays high.
- `out_data_o` and `out_eop_o` hold stable while `out_valid_o & !out_ready_i`.
- The first PAD cycle may overlap the eop word still waiting in the output register; pad dropping never stalls on the engine.

## Structure
- Package `comp_pkg` holds:
  - `DATA_W`, `BLOCK_WORDS`, `SIZE_W`.
  - Enum `strip_state_e {IDLE, PAYLOAD, PAD}`.
  - Function `pay_words(comp_size) = comp_size + 1`, shared with the pad generator.
- One sub-module, `out_reg_slice`: the single-entry valid/ready register carrying data and eop. FSM and counters stay in the top level.

## Test plan
- comp_size_i=3, 8 words with words 4..7 zero, `out_ready_i`=1 → 4 output words, eop on the 4th, `in_ready_o` high for all 8 cycles, no errors.
- comp_size_i=7 → 8 payload words with eop on the 8th, no PAD state; next sop accepted the cycle after.
- comp_size_i=0, pad word 5 = 0x1 → 1 output word with eop, `pad_err_o` rises the cycle after word 5 and stays high.
- comp_size_i=5, `out_ready_i` toggling 1/0 → no payload lost or duplicated, data stable while stalled, eop on the 6th word.
- sop at word 3 of a comp_size_i=6 block → `frame_err_o`=1, new block decoded correctly from that word; non-sop word in IDLE → dropped, `frame_err_o`=1.
- `rst` asserted mid-PAYLOAD with `out_valid_o`=1 → next cycle all outputs at reset values; next sop block decodes normally.
